piso_frame_ctrl: RTL
====================

// Module: piso_frame_ctrl
// PURPOSE
//  Upstream sequencer for the 4-bit universal shift register: accepts parallel words over a
//  valid/ready handshake and serialises them onto a single line. Drives the register's
//  s1/s0 mode codes: load, then shift WIDTH times, with hold on back-pressure.
//  Contains its own register instance. Exports the mode it applies so the downstream
//  register/bench can track it.
// PARAMETERS
//  WIDTH      4  word width and bits per frame (>=2)
//  LSB_FIRST  1  1: shift right, LSB out first; 0: shift left, MSB out first
//  GAP        0  idle cycles forced after each frame's last bit (0..15)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   WIDTH  parallel word
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept a word this cycle
//  ser_out    out  1      current serial bit
//  ser_valid  out  1      ser_out carries a frame bit
//  ser_ready  in   1      consumer takes ser_out this cycle
//  ser_last   out  1      ser_out is the final bit of the frame
//  mode       out  2      applied {s1,s0}: 00 hold, 01 shift right, 10 shift left, 11 load
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, shift reg 0, bit count 0, gap count 0,
//    ser_valid=0, ser_last=0, mode=00, busy=0. in_ready=0 while rst_n=0.
//  - FSM IDLE -> SHIFT -> (GAP if GAP>0) -> IDLE.
//  - IDLE: in_ready=1, mode=00. On in_valid&in_ready: mode=11, load in_data, count=0,
//    go SHIFT. First bit is on ser_out in the next cycle (1-cycle latency).
//  - SHIFT: ser_valid=1. ser_out = reg[0] if LSB_FIRST, else reg[WIDTH-1].
//    ser_last=1 when count==WIDTH-1.
//    On ser_ready=1: mode=01 (LSB_FIRST) or 10, serial fill 0, count++.
//    On ser_ready=0: mode=00; reg, count and ser_out held unchanged.
//  - Last bit accepted (ser_last&ser_ready):
//    - GAP>0: go GAP, gap count=GAP.
//    - GAP=0: in_ready=1 in this same cycle. If in_valid=1, mode=11 loads the next word
//      and stays in SHIFT: zero-bubble streaming. Else go IDLE.
//  - GAP: ser_valid=0, in_ready=0, mode=00. Decrement gap count each cycle. Go IDLE when
//    it reaches 1.
//  - in_valid while in SHIFT (other than the last-bit case) or in GAP: ignored,
//    in_ready=0. The source holds the word.
//  - ser_valid, ser_last and ser_out are all from registers/state, with no combinational
//    path from ser_ready. in_ready is combinational from state, count and ser_ready only.
//  - Count is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//  - Reset mid-frame aborts the frame. No partial word is retained.
// STRUCTURE
//  - shift_defs package/header: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10,
//    MODE_LOAD=2'b11; state codes ST_IDLE, ST_SHIFT, ST_GAP.
//  - Sub-module uni_shift_reg #(WIDTH): clk, rst_n, mode, par_in, sr_in (right fill),
//    sl_in (left fill), q. Same mode semantics as the existing 4-bit register.
//  - Top level holds only the FSM, counters and handshake logic.
// TESTING (WIDTH=4 unless stated)
//  1 Reset: rst_n=0 for 2 cycles, then 1. Expect all outputs at reset values, then in_ready=1
//    and mode=00.
//  2 LSB_FIRST=1, load 4'b0110, ser_ready=1. Expect ser_out 0,1,1,0 in cycles 1-4,
//    ser_last only in cycle 4, mode 11,01,01,01,01, then IDLE.
//  3 GAP=0, words 4'b0110 then 4'b1001 with in_valid held. Expect 8 contiguous ser_valid
//    bits 0,1,1,0,1,0,0,1 with no bubble, and 2nd load in the ser_last cycle.
//  4 Back-pressure: drop ser_ready for 3 cycles on the 2nd bit of 4'b0110. Expect ser_out
//    held at 1, mode=00, count unchanged, frame resumes intact.
//  5 LSB_FIRST=0, load 4'b0011. Expect ser_out 0,0,1,1 with mode 10 on shifts.
//    LSB_FIRST=1 with the same word gives 1,1,0,0.
//  6 GAP=2: two back-to-back words. Expect exactly 2 cycles with ser_valid=0 and
//    in_ready=0 between frames. Also: rst_n=0 during bit 3 gives immediate ser_valid=0,
//    and after release the next frame starts clean.

Source files
------------

// File: rtl/piso_frame_ctrl_pkg.sv
// Shared definitions for the parallel-in/serial-out frame controller:
// register mode codes, FSM state codes and small helpers.
package piso_frame_ctrl_pkg;

  // {s1,s0} mode codes understood by the universal shift register
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  // Gap counter covers inter-frame gaps of 0..15 cycles
  localparam int GAP_CNT_W = 4;

  // Shift direction that moves the next frame bit onto the serial tap
  function automatic mode_e shift_mode(input bit lsb_first);
    return lsb_first ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/piso_frame_ctrl_if.sv
// Word-in / bit-out bus of the frame controller. The controller is the
// slave (takes words, produces serial bits); the source/sink side is master.
interface piso_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic [1:0]       mode;
  logic             busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, mode, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last, mode, busy
  );
endinterface

// File: rtl/piso_frame_ctrl_uni_shift_reg.sv
// Universal shift register: hold, shift right (fill from sr_in at the MSB),
// shift left (fill from sl_in at the LSB) or parallel load, selected by mode.
module uni_shift_reg
  import piso_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_upper; // bit that lands here on a right shift
      logic from_lower; // bit that lands here on a left shift

      if (gi == WIDTH - 1) begin : g_top
        assign from_upper = sr_in;
      end else begin : g_mid_up
        assign from_upper = q_q[gi+1];
      end

      if (gi == 0) begin : g_bottom
        assign from_lower = sl_in;
      end else begin : g_mid_dn
        assign from_lower = q_q[gi-1];
      end

      assign q_d[gi] = (mode == MODE_LOAD) ? par_in[gi]  :
                       (mode == MODE_SHR)  ? from_upper  :
                       (mode == MODE_SHL)  ? from_lower  :
                                             q_q[gi];
    end
  endgenerate

  // Register the selected next value; reset clears any partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer in front of a universal shift register: takes parallel
// words on a valid/ready handshake, loads them, then shifts WIDTH bits out
// under ser_ready flow control, with an optional forced idle gap per frame.
module piso_frame_ctrl
  import piso_frame_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_frame_ctrl_if.slave  bus
);

  localparam int                   CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_INIT   = GAP_CNT_W'(GAP);
  localparam bit                   HAS_GAP    = (GAP > 0);
  localparam mode_e                SHIFT_MODE = shift_mode(LSB_FIRST != 0);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   ser_valid_q, ser_valid_d;
  logic                   ser_last_q, ser_last_d;
  mode_e                  mode_d;
  logic                   in_ready;
  logic                   accept;
  logic [WIDTH-1:0]       sr_q;

  // Word acceptance: always in IDLE, and on the accepted last bit when no
  // gap is configured so back-to-back frames stream without a bubble
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (state_q == ST_IDLE) begin
        in_ready = 1'b1;
      end else if (!HAS_GAP && (state_q == ST_SHIFT) &&
                   (cnt_q == LAST_CNT) && bus.ser_ready) begin
        in_ready = 1'b1;
      end
    end
  end

  assign accept = bus.in_valid & in_ready;

  // Next-state, counter and applied register mode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    mode_d    = MODE_HOLD;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d  = MODE_LOAD;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Without ser_ready everything holds, including the bit on ser_out
        if (bus.ser_ready) begin
          mode_d = SHIFT_MODE;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_INIT;
            end else if (accept) begin
              // Reload replaces the final shift; stay in SHIFT
              mode_d = MODE_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= GAP_CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Serial flags are precomputed so they come straight from flops
    ser_valid_d = (state_d == ST_SHIFT);
    ser_last_d  = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
  end

  // Sequencer state and registered serial flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  uni_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode_d),
    .par_in (bus.in_data),
    .sr_in  (1'b0),
    .sl_in  (1'b0),
    .q      (sr_q)
  );

  // Serial tap sits at the end the register shifts towards
  generate
    if (LSB_FIRST != 0) begin : g_tap_lsb
      assign bus.ser_out = sr_q[0];
    end else begin : g_tap_msb
      assign bus.ser_out = sr_q[WIDTH-1];
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.mode      = mode_d;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
